multicycle_ctrl: RTL and testbench

- Multicycle control unit for the RV32I core.
- Replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory request/ready handshake with a wait-cycle timeout counter.
- Drives datapath muxes and enables. Sits between the instruction register (op, Zero) and the datapath/unified memory port.

---
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake between the multicycle control unit and memory.
// The controller is the master: it raises MemReq and memory answers with MemReady.
interface multicycle_ctrl_if;
    logic MemReq;
    logic MemWrite;
    logic AdrSrc;
    logic MemReady;

    modport master (output MemReq, output MemWrite, output AdrSrc, input MemReady);
    modport slave  (input MemReq, input MemWrite, input AdrSrc, output MemReady);
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control: Moore FSM sequencing fetch/decode/execute/mem/writeback
// with a memory wait timeout. Optional MULTICYCLE_ILLEGAL_TRAP_EN adds TRAP + IllegalInstr.
module multicycle_ctrl #(
    parameter int TIMEOUT_W      = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic                Zero,
    multicycle_ctrl_if.master   mem,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ImmSrc,
    output logic [1:0]          ALUOp,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    output logic                IllegalInstr,
`endif
    output logic                MemTimeout
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALRWB, S_LUI
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   r_timeout;
    logic                   w_pcupdate;
    logic                   w_branch;
    logic                   w_in_mem;
    logic                   w_next_mem;

    assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_next_mem = (w_next == S_FETCH) || (w_next == S_MEMREAD) || (w_next == S_MEMWRITE);
    assign MemTimeout = r_timeout;
    assign PCWrite    = w_pcupdate | (w_branch & Zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_BOOT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT:     w_next = S_FETCH;
            S_FETCH:    if (mem.MemReady) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = S_JALR;
                    OP_LUI:       w_next = S_LUI;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:      w_next = S_TRAP;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem.MemReady) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem.MemReady) w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_JALRWB;
            S_JALRWB:   w_next = S_FETCH;
            S_LUI:      w_next = S_ALUWB;
            default:    w_next = r_state;
        endcase
    end

    always_comb begin
        mem.MemReq   = 1'b0;
        mem.MemWrite = 1'b0;
        mem.AdrSrc   = 1'b0;
        IRWrite      = 1'b0;
        w_pcupdate   = 1'b0;
        w_branch     = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        IllegalInstr = (r_state == S_TRAP);
`endif
        // Immediate format follows the opcode everywhere except the all-zero states.
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BEQ:  ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
        case (r_state)
            S_FETCH: begin
                mem.MemReq = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = mem.MemReady;
                w_pcupdate = mem.MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem.MemReq = 1'b1;
                mem.AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem.MemReq   = 1'b1;
                mem.MemWrite = 1'b1;
                mem.AdrSrc   = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_JALRWB: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            default: ImmSrc = 3'b000;
        endcase
    end

    // Wait counter restarts on every memory-state entry and on each completed access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((w_next_mem && (w_next != r_state)) || (w_in_mem && mem.MemReady))
                r_cnt <= '0;
            else if (w_in_mem && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + 1'b1;
            if (w_in_mem && (r_cnt >= CNT_LIM))
                r_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: stimulus queues hand-computed
// expected control words, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] ILL  = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       Zero;
    logic       IRWrite, PCWrite, RegWrite, MemTimeout;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       w_ill;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.TIMEOUT_W(4), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem(mif.master),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUOp(ALUOp),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        .IllegalInstr(w_ill),
`endif
        .MemTimeout(MemTimeout)
    );

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    assign w_ill = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] v;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [18:0] act;

    assign act = {w_ill, mif.MemReq, mif.MemWrite, mif.AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, MemTimeout};

    function automatic logic [18:0] ev(input bit req, input bit wr, input bit adr,
                                       input bit irw, input bit pcw, input bit rgw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] imm,
                                       input logic [1:0] aop, input bit to, input bit ill = 1'b0);
        return {ill, req, wr, adr, irw, pcw, rgw, rs, sa, sb, imm, aop, to};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b (ill,req,wr,adr,irw,pcw,rgw,rs,sa,sb,imm,aop,to)",
                         e.name, act, e.v);
            end
        end
    end

    task automatic cyc(input logic [6:0] o, input logic z, input logic rdy,
                       input logic [18:0] e, input string nm);
        @(posedge clk); #1;
        op = o; Zero = z; mif.MemReady = rdy;
        q.push_back('{e, nm});
    endtask

    task automatic rst_cyc(input logic r, input logic [6:0] o, input string nm);
        @(posedge clk); #1;
        reset = r; op = o; mif.MemReady = 1'b1;
        q.push_back('{19'd0, nm});
    endtask

    // FETCH with MemReady, then DECODE with MemReady low to show it is ignored there.
    task automatic fetch_dec(input logic [6:0] o, input logic [2:0] imm, input bit to);
        cyc(o, 1'b0, 1'b1, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,imm,2'b00,to), "fetch");
        cyc(o, 1'b0, 1'b0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,imm,2'b00,to), "decode");
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; Zero = 1'b0; mif.MemReady = 1'b1;
        rst_cyc(1'b1, 7'd0, "reset_state");
        rst_cyc(1'b0, 7'd0, "boot");

        fetch_dec(LW, 3'b000, 1'b0);
        cyc(LW, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "lw_memadr");
        cyc(LW, 0, 1, ev(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), "lw_memread");
        cyc(LW, 0, 0, ev(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0), "lw_memwb");

        cyc(RT, 0, 0, ev(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "fetch_wait1");
        cyc(RT, 0, 0, ev(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "fetch_wait2");
        fetch_dec(RT, 3'b000, 1'b0);
        cyc(RT, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b10,0), "r_exec");
        cyc(RT, 0, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "r_aluwb");

        fetch_dec(IT, 3'b000, 1'b0);
        cyc(IT, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b10,0), "i_exec");
        cyc(IT, 0, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "i_aluwb");

        fetch_dec(LUI, 3'b100, 1'b0);
        cyc(LUI, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,2'b00,0), "lui");
        cyc(LUI, 0, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b100,2'b00,0), "lui_aluwb");

        fetch_dec(BEQ, 3'b010, 1'b0);
        cyc(BEQ, 1, 0, ev(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b010,2'b01,0), "beq_taken");
        fetch_dec(BEQ, 3'b010, 1'b0);
        cyc(BEQ, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b01,0), "beq_not_taken");

        fetch_dec(JAL, 3'b011, 1'b0);
        cyc(JAL, 0, 0, ev(0,0,0,0,1,0,2'b00,2'b01,2'b10,3'b011,2'b00,0), "jal");
        cyc(JAL, 0, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b011,2'b00,0), "jal_aluwb");

        fetch_dec(JALR, 3'b000, 1'b0);
        cyc(JALR, 0, 0, ev(0,0,0,0,1,0,2'b10,2'b10,2'b01,3'b000,2'b00,0), "jalr");
        cyc(JALR, 0, 0, ev(0,0,0,0,0,1,2'b10,2'b01,2'b10,3'b000,2'b00,0), "jalrwb");

        fetch_dec(SW, 3'b001, 1'b0);
        cyc(SW, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,2'b00,0), "sw_memadr");
        cyc(SW, 0, 1, ev(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b001,2'b00,0), "sw_memwrite");

        // Store stalled 20 cycles: flag appears in the 17th wait cycle and sticks.
        fetch_dec(SW, 3'b001, 1'b0);
        cyc(SW, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,2'b00,0), "sw2_memadr");
        for (int k = 1; k <= 20; k++)
            cyc(SW, 0, 0, ev(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b001,2'b00,(k >= 17)),
                $sformatf("sw_wait%0d", k));
        cyc(SW, 0, 1, ev(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b001,2'b00,1), "sw_ready_late");
        cyc(RT, 0, 0, ev(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,1), "timeout_sticky");
        rst_cyc(1'b1, RT, "reset_mid_fetch");
        rst_cyc(1'b0, RT, "boot_after_reset");
        fetch_dec(RT, 3'b000, 1'b0);
        cyc(RT, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b10,0), "r_after_reset");
        cyc(RT, 0, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "aluwb_after_reset");

        fetch_dec(ILL, 3'b000, 1'b0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++)
            cyc(ILL, 0, 1, ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1), "trap_hold");
        rst_cyc(1'b1, ILL, "reset_mid_trap");
        rst_cyc(1'b0, LW, "boot_after_trap");
        cyc(LW, 0, 1, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "fetch_after_trap");
`else
        cyc(ILL, 0, 1, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "nop_to_fetch");
`endif

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
